// File: rtl/decoder_scan.sv
// Registered N-to-2^N select decoder with a programmable-rate scan sequencer.
// Optional macro DECODER_SCAN_BLANK_EN blanks Y for the TICK cycle of each scan step.
module decoder_scan #(
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned DIV_W      = 16,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN,
  input  logic                    MODE,
  input  logic                    LOAD,
  input  logic [SEL_W-1:0]        SEL,
  input  logic [DIV_W-1:0]        DIV,
  input  logic [SEL_W-1:0]        LAST,
  output logic [(2**SEL_W)-1:0]   Y,
  output logic [SEL_W-1:0]        IDX,
  output logic                    TICK
);

  localparam int unsigned N = 2**SEL_W;

  localparam logic [N-1:0]     INACTIVE = {N{ACTIVE_LOW}};
  localparam logic [N-1:0]     ONE_HOT0 = N'(1);
  localparam logic [SEL_W-1:0] IDX_ONE  = SEL_W'(1);
  localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);

  logic [SEL_W-1:0] idx_q, idx_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     y_q, y_d;
  logic             tick_q, tick_d;
  logic [N-1:0]     hot;

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;

    if (LOAD) begin
      idx_d = SEL;
      cnt_d = '0;
    end else if (EN) begin
      if (!MODE) begin
        cnt_d = '0;
      end else if (cnt_q >= DIV) begin
        // >= so that lowering DIV below the running count steps immediately
        cnt_d  = '0;
        tick_d = 1'b1;
        idx_d  = (idx_q >= LAST) ? '0 : idx_q + IDX_ONE;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    hot = ONE_HOT0 << idx_d;
    y_d = ACTIVE_LOW ? ~hot : hot;
`ifdef DECODER_SCAN_BLANK_EN
    if (!EN || tick_d) y_d = INACTIVE;
`else
    if (!EN) y_d = INACTIVE;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      y_q    <= INACTIVE;
      tick_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      y_q    <= y_d;
      tick_q <= tick_d;
    end
  end

  assign Y    = y_q;
  assign IDX  = idx_q;
  assign TICK = tick_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed self-checking bench for decoder_scan: default build plus a
// SEL_W=2 one-hot instance; expectations follow DECODER_SCAN_BLANK_EN when set.
module tb_decoder_scan;

`ifdef DECODER_SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst, en, mode, load;
  logic [2:0]  sel, last;
  logic [15:0] div;
  logic [7:0]  y;
  logic [2:0]  idx;
  logic        tick;

  logic        rst2, en2, mode2, load2;
  logic [1:0]  sel2, last2;
  logic [15:0] div2;
  logic [3:0]  y2;
  logic [1:0]  idx2;
  logic        tick2;

  int checks = 0;
  int errors = 0;

  logic [7:0] dec8 [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [3:0] dec4 [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  decoder_scan u_dut (
    .CLK(CLK), .RST(rst), .EN(en), .MODE(mode), .LOAD(load),
    .SEL(sel), .DIV(div), .LAST(last), .Y(y), .IDX(idx), .TICK(tick)
  );

  decoder_scan #(.SEL_W(2), .ACTIVE_LOW(1'b0)) u_dut2 (
    .CLK(CLK), .RST(rst2), .EN(en2), .MODE(mode2), .LOAD(load2),
    .SEL(sel2), .DIV(div2), .LAST(last2), .Y(y2), .IDX(idx2), .TICK(tick2)
  );

  task automatic clk1();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; sel = '0; div = '0; last = 3'd7;
    clk1();
    checks++; if (y !== 8'hFF) begin errors++; $display("FAIL reset_y got %h exp %h", y, 8'hFF); end
    checks++; if (idx !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", idx); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", tick); end
    rst = 1'b0; en = 1'b1;
    clk1();
    checks++; if (y !== 8'hFE) begin errors++; $display("FAIL first_en_y got %h exp %h", y, 8'hFE); end
    for (int i = 0; i < 8; i++) begin
      load = 1'b1; sel = 3'(i);
      clk1();
      checks++; if (y !== dec8[i]) begin errors++; $display("FAIL load_y sel=%0d got %h exp %h", i, y, dec8[i]); end
      checks++; if (idx !== 3'(i)) begin errors++; $display("FAIL load_idx sel=%0d got %0d exp %0d", i, idx, i); end
    end
    load = 1'b0;
  endtask

  task automatic test_scan_wrap();
    logic [2:0] ei;
    logic       et;
    logic [7:0] ey;
    mode = 1'b0; load = 1'b1; sel = '0;
    clk1();
    load = 1'b0; mode = 1'b1; div = 16'd2; last = 3'd5;
    for (int k = 1; k <= 21; k++) begin
      clk1();
      ei = 3'((k / 3) % 6);
      et = (k % 3 == 0);
      ey = (BLANK && et) ? 8'hFF : dec8[ei];
      checks++; if (idx !== ei) begin errors++; $display("FAIL scan_idx k=%0d got %0d exp %0d", k, idx, ei); end
      checks++; if (tick !== et) begin errors++; $display("FAIL scan_tick k=%0d got %b exp %b", k, tick, et); end
      checks++; if (y !== ey) begin errors++; $display("FAIL scan_y k=%0d got %h exp %h", k, y, ey); end
    end
  endtask

  task automatic test_enable_freeze();
    mode = 1'b1; div = 16'd3; last = 3'd7; load = 1'b1; sel = '0;
    clk1();
    checks++; if (idx !== 3'd0 || tick !== 1'b0) begin errors++; $display("FAIL frz_load idx=%0d tick=%b exp 0/0", idx, tick); end
    load = 1'b0;
    clk1();
    clk1();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      clk1();
      checks++; if (y !== 8'hFF) begin errors++; $display("FAIL frz_y k=%0d got %h exp FF", k, y); end
      checks++; if (idx !== 3'd0 || tick !== 1'b0) begin errors++; $display("FAIL frz_idx k=%0d idx=%0d tick=%b exp 0/0", k, idx, tick); end
    end
    en = 1'b1;
    clk1();
    checks++; if (y !== 8'hFE || idx !== 3'd0 || tick !== 1'b0) begin errors++; $display("FAIL resume1 y=%h idx=%0d tick=%b exp FE/0/0", y, idx, tick); end
    clk1();
    checks++; if (idx !== 3'd1 || tick !== 1'b1) begin errors++; $display("FAIL resume2 idx=%0d tick=%b exp 1/1", idx, tick); end
    checks++; if (y !== (BLANK ? 8'hFF : 8'hFD)) begin errors++; $display("FAIL resume2_y got %h exp %h", y, BLANK ? 8'hFF : 8'hFD); end
  endtask

  task automatic test_priority();
    logic [2:0] seq [4] = '{3'd1, 3'd2, 3'd0, 3'd1};
    for (int k = 0; k < 3; k++) begin
      clk1();
      checks++; if (tick !== 1'b0 || idx !== 3'd1) begin errors++; $display("FAIL pri_pre k=%0d idx=%0d tick=%b exp 1/0", k, idx, tick); end
    end
    load = 1'b1; sel = 3'd4;
    clk1();
    checks++; if (idx !== 3'd4 || tick !== 1'b0 || y !== 8'hEF) begin errors++; $display("FAIL pri_load idx=%0d tick=%b y=%h exp 4/0/EF", idx, tick, y); end
    load = 1'b0; last = 3'd2;
    for (int k = 0; k < 3; k++) begin
      clk1();
      checks++; if (idx !== 3'd4 || tick !== 1'b0) begin errors++; $display("FAIL pri_wait k=%0d idx=%0d tick=%b exp 4/0", k, idx, tick); end
    end
    clk1();
    checks++; if (idx !== 3'd0 || tick !== 1'b1) begin errors++; $display("FAIL last_wrap idx=%0d tick=%b exp 0/1", idx, tick); end
    checks++; if (y !== (BLANK ? 8'hFF : 8'hFE)) begin errors++; $display("FAIL last_wrap_y got %h exp %h", y, BLANK ? 8'hFF : 8'hFE); end
    div = 16'd0;
    for (int k = 0; k < 4; k++) begin
      clk1();
      checks++; if (idx !== seq[k] || tick !== 1'b1) begin errors++; $display("FAIL div0 k=%0d idx=%0d tick=%b exp %0d/1", k, idx, tick, seq[k]); end
      checks++; if (y !== (BLANK ? 8'hFF : dec8[seq[k]])) begin errors++; $display("FAIL div0_y k=%0d got %h exp %h", k, y, BLANK ? 8'hFF : dec8[seq[k]]); end
    end
  endtask

  task automatic test_blank();
    logic [7:0] ey_b [5] = '{8'hFE, 8'hFF, 8'hFD, 8'hFF, 8'hFB};
    logic [7:0] ey_n [5] = '{8'hFE, 8'hFD, 8'hFD, 8'hFB, 8'hFB};
    logic       et   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    en = 1'b1; mode = 1'b1; div = 16'd1; last = 3'd7; load = 1'b1; sel = '0;
    clk1();
    checks++; if (y !== 8'hFE) begin errors++; $display("FAIL blank_load_y got %h exp FE", y); end
    load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      clk1();
      checks++; if (y !== (BLANK ? ey_b[k] : ey_n[k])) begin errors++; $display("FAIL blank_y k=%0d got %h exp %h", k, y, BLANK ? ey_b[k] : ey_n[k]); end
      checks++; if (tick !== et[k]) begin errors++; $display("FAIL blank_tick k=%0d got %b exp %b", k, tick, et[k]); end
    end
  endtask

  task automatic test_params();
    rst2 = 1'b1; en2 = 1'b0; mode2 = 1'b0; load2 = 1'b0; sel2 = '0; div2 = '0; last2 = 2'd3;
    clk1();
    checks++; if (y2 !== 4'b0000) begin errors++; $display("FAIL p_reset_y got %b exp 0000", y2); end
    rst2 = 1'b0; en2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load2 = 1'b1; sel2 = 2'(i);
      clk1();
      checks++; if (y2 !== dec4[i]) begin errors++; $display("FAIL p_load_y sel=%0d got %b exp %b", i, y2, dec4[i]); end
    end
    load2 = 1'b0; en2 = 1'b0;
    clk1();
    checks++; if (y2 !== 4'b0000 || idx2 !== 2'd3) begin errors++; $display("FAIL p_en0 y=%b idx=%0d exp 0000/3", y2, idx2); end
    en2 = 1'b1; mode2 = 1'b1; div2 = 16'd1; load2 = 1'b1; sel2 = '0;
    clk1();
    load2 = 1'b0;
    clk1();
    clk1();
    checks++; if (y2 !== 4'b0010 || idx2 !== 2'd1 || tick2 !== 1'b1) begin errors++; $display("FAIL p_scan y=%b idx=%0d tick=%b exp 0010/1/1", y2, idx2, tick2); end
    #3 rst2 = 1'b1;
    #1;
    checks++; if (y2 !== 4'b0000 || idx2 !== 2'd0 || tick2 !== 1'b0) begin errors++; $display("FAIL p_async_rst y=%b idx=%0d tick=%b exp 0000/0/0", y2, idx2, tick2); end
    clk1();
    rst2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; sel = '0; div = '0; last = '0;
    rst2 = 1'b1; en2 = 1'b0; mode2 = 1'b0; load2 = 1'b0; sel2 = '0; div2 = '0; last2 = '0;
    test_reset();
    test_scan_wrap();
    test_enable_freeze();
    test_priority();
    test_blank();
    test_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
